// File: rtl/hub75_bcm_driver.sv
// HUB75 LED panel scanner with binary-coded modulation of BPC bit planes.
// Ports: clk/rst (async high), enable, rd_addr/rd_data framebuffer read,
// H75_* panel pins, frame_start one-clk pulse at the line wrap.
module hub75_bcm_driver #(
    parameter int COLS     = 64,
    parameter int ROW_BITS = 5,
    parameter int BPC      = 4,
    parameter int CLK_DIV  = 27,
    parameter int BASE_OE  = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    output logic [ROW_BITS+$clog2(COLS)-1:0]   rd_addr,
    input  logic [6*BPC-1:0]                   rd_data,
    output logic                               H75_R1,
    output logic                               H75_G1,
    output logic                               H75_B1,
    output logic                               H75_R2,
    output logic                               H75_G2,
    output logic                               H75_B2,
    output logic                               H75_A,
    output logic                               H75_B,
    output logic                               H75_C,
    output logic                               H75_D,
    output logic                               H75_E,
    output logic                               H75_Clk,
    output logic                               H75_Lat,
    output logic                               H75_OE,
    output logic                               frame_start
);
    localparam int CB         = $clog2(COLS);
    localparam int SHIFT_LAST = 2 * COLS;
    localparam int SHOW_MAX   = BASE_OE << (BPC - 1);
    localparam int CNT_MAX    = (SHIFT_LAST > SHOW_MAX) ? SHIFT_LAST : SHOW_MAX;
    localparam int CW         = $clog2(CNT_MAX + 1);
    localparam int DW         = $clog2(CLK_DIV);
    localparam int PW         = (BPC > 1) ? $clog2(BPC) : 1;

    typedef enum logic [2:0] {
        IDLE, SHIFT, BLANK, LATCH_HI, LATCH_LO, SHOW
    } state_t;

    state_t              state_q;
    logic [DW-1:0]       div_q;
    logic [CW-1:0]       cnt_q;
    logic [ROW_BITS-1:0] line_q;
    logic [PW-1:0]       plane_q;
    logic [ROW_BITS-1:0] row_q;
    logic [5:0]          rgb_q;
    logic                clk_q;
    logic                lat_q;
    logic                oe_q;
    logic                fs_q;

    logic                tick;
    logic                last_plane;
    logic                wrap;
    logic                show_last;
    logic [PW-1:0]       plane_d;
    logic [ROW_BITS-1:0] line_d;
    logic [CB-1:0]       col;
    logic [ROW_BITS-1:0] aline;
    logic [4:0]          row5;

    assign tick       = (div_q == DW'(CLK_DIV - 1));
    assign last_plane = (plane_q == PW'(BPC - 1));
    assign plane_d    = last_plane ? '0 : plane_q + PW'(1);
    assign line_d     = last_plane ? line_q + ROW_BITS'(1) : line_q;
    assign wrap       = last_plane && (line_q == '1);
    assign show_last  = (cnt_q == (CW'(BASE_OE) << plane_q) - CW'(1));

    // Bit p of each channel; bit 5 is R1, bit 0 is B2.
    function automatic logic [5:0] pick(input logic [6*BPC-1:0] d,
                                        input logic [PW-1:0] p);
        logic [5:0] r;
        for (int j = 0; j < 6; j++) begin
            r[j] = d[j*BPC + int'(p)];
        end
        return r;
    endfunction

    // Address runs one column ahead of the shifter so the registered
    // framebuffer has a full tick to answer. During SHOW it already
    // points at column 0 of the position the next SHIFT will use.
    always_comb begin
        col   = '0;
        aline = line_q;
        if (state_q == SHIFT) begin
            col = CB'((cnt_q >> 1) + CW'(1));
        end
        if (state_q == SHOW) begin
            aline = line_d;
        end
    end

    assign rd_addr = {aline, col};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            line_q  <= '0;
            plane_q <= '0;
            row_q   <= '0;
            rgb_q   <= '0;
            clk_q   <= 1'b0;
            lat_q   <= 1'b0;
            oe_q    <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            fs_q  <= 1'b0;
            div_q <= tick ? '0 : div_q + DW'(1);
            if (tick) begin
                unique case (state_q)
                    IDLE: begin
                        if (enable) begin
                            state_q <= SHIFT;
                            cnt_q   <= '0;
                            clk_q   <= 1'b0;
                            rgb_q   <= pick(rd_data, plane_q);
                        end
                    end
                    SHIFT: begin
                        if (cnt_q == CW'(SHIFT_LAST)) begin
                            state_q <= BLANK;
                            oe_q    <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                            if (!cnt_q[0]) begin
                                clk_q <= 1'b1;
                            end else begin
                                clk_q <= 1'b0;
                                // The tick after the last rising edge only
                                // returns the clock low.
                                if (cnt_q != CW'(SHIFT_LAST - 1)) begin
                                    rgb_q <= pick(rd_data, plane_q);
                                end
                            end
                        end
                    end
                    BLANK: begin
                        state_q <= LATCH_HI;
                        lat_q   <= 1'b1;
                        row_q   <= line_q;
                    end
                    LATCH_HI: begin
                        state_q <= LATCH_LO;
                        lat_q   <= 1'b0;
                    end
                    LATCH_LO: begin
                        state_q <= SHOW;
                        oe_q    <= 1'b0;
                        cnt_q   <= '0;
                    end
                    SHOW: begin
                        if (show_last) begin
                            oe_q    <= 1'b1;
                            plane_q <= plane_d;
                            line_q  <= line_d;
                            fs_q    <= wrap;
                            if (enable) begin
                                state_q <= SHIFT;
                                cnt_q   <= '0;
                                clk_q   <= 1'b0;
                                rgb_q   <= pick(rd_data, plane_d);
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign row5        = 5'(row_q);
    assign H75_R1      = rgb_q[5];
    assign H75_G1      = rgb_q[4];
    assign H75_B1      = rgb_q[3];
    assign H75_R2      = rgb_q[2];
    assign H75_G2      = rgb_q[1];
    assign H75_B2      = rgb_q[0];
    assign H75_A       = row5[0];
    assign H75_B       = row5[1];
    assign H75_C       = row5[2];
    assign H75_D       = row5[3];
    assign H75_E       = row5[4];
    assign H75_Clk     = clk_q;
    assign H75_Lat     = lat_q;
    assign H75_OE      = oe_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Bench for hub75_bcm_driver: small panel against a framebuffer model,
// plus a default-parameter instance for shift-clock and OE timing.
module tb_hub75_bcm_driver;
    localparam int COLS = 4, ROW_BITS = 2, BPC = 2, CLK_DIV = 2, BASE_OE = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, enable = 1'b0;
    logic [3:0]  rd_addr;
    logic [11:0] rd_data;
    logic r1, g1, b1, r2, g2, b2, ha, hb, hc, hd, he, hclk, hlat, hoe, fs;

    hub75_bcm_driver #(.COLS(COLS), .ROW_BITS(ROW_BITS), .BPC(BPC),
                       .CLK_DIV(CLK_DIV), .BASE_OE(BASE_OE)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .H75_R1(r1), .H75_G1(g1), .H75_B1(b1),
        .H75_R2(r2), .H75_G2(g2), .H75_B2(b2),
        .H75_A(ha), .H75_B(hb), .H75_C(hc), .H75_D(hd), .H75_E(he),
        .H75_Clk(hclk), .H75_Lat(hlat), .H75_OE(hoe), .frame_start(fs)
    );

    logic [11:0] fb [16];
    always @(posedge clk) rd_data <= fb[rd_addr];

    // default-parameter instance
    logic        rst2 = 1'b1, en2 = 1'b1;
    logic [10:0] rd_addr2;
    logic [23:0] rd_data2 = 24'hA5C3F0;
    logic q_r1, q_g1, q_b1, q_r2, q_g2, q_b2, q_a, q_b, q_c, q_d, q_e;
    logic q_clk, q_lat, q_oe, q_fs;

    hub75_bcm_driver dut2 (
        .clk(clk), .rst(rst2), .enable(en2),
        .rd_addr(rd_addr2), .rd_data(rd_data2),
        .H75_R1(q_r1), .H75_G1(q_g1), .H75_B1(q_b1),
        .H75_R2(q_r2), .H75_G2(q_g2), .H75_B2(q_b2),
        .H75_A(q_a), .H75_B(q_b), .H75_C(q_c), .H75_D(q_d), .H75_E(q_e),
        .H75_Clk(q_clk), .H75_Lat(q_lat), .H75_OE(q_oe), .frame_start(q_fs)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One observed line/plane: latched row, shift-clock count,
    // colour bits at each rising edge, OE-low length, frame_start.
    typedef struct {
        int          row;
        int          nclk;
        logic [47:0] s;
        int          oe_clks;
        int          fs;
    } grp_t;

    grp_t cur;
    grp_t obs[$];
    int   ns = 0, oe_cnt = 0, fs_count = 0, inv_prints = 0;
    logic prev_clk = 1'b0, prev_lat = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            ns = 0; oe_cnt = 0; prev_clk = 1'b0; prev_lat = 1'b0;
        end else begin
            checks++;
            if ((hlat && !hoe) || (hclk && (hlat || !hoe))) begin
                errors++;
                if (inv_prints < 10)
                    $display("FAIL invariant: lat=%0b oe=%0b clk=%0b required lat&oe_n and quiet clk",
                             hlat, hoe, hclk);
                inv_prints++;
            end
            if (hclk && !prev_clk) begin
                if (ns < 8) cur.s[6*ns +: 6] = {r1, g1, b1, r2, g2, b2};
                ns++;
            end
            if (hlat && !prev_lat) begin
                cur.row = {30'd0, hb, ha};
                cur.nclk = ns;
                ns = 0;
            end
            if (!hoe) oe_cnt++;
            else if (oe_cnt > 0) begin
                cur.oe_clks = oe_cnt;
                cur.fs = int'(fs);
                obs.push_back(cur);
                oe_cnt = 0;
            end
            if (fs) fs_count++;
            prev_clk = hclk;
            prev_lat = hlat;
        end
    end

    int cyc2 = 0, last_rise2 = -1, period2 = 0, run2 = 0, nruns2 = 0, run3_len = 0;
    logic pc2 = 1'b0;
    always @(negedge clk) begin
        if (!rst2) begin
            cyc2++;
            if (q_clk && !pc2) begin
                if (last_rise2 >= 0 && period2 == 0) period2 = cyc2 - last_rise2;
                last_rise2 = cyc2;
            end
            pc2 = q_clk;
            if (!q_oe) run2++;
            else if (run2 > 0) begin
                if (nruns2 == 3) run3_len = run2;
                nruns2++;
                run2 = 0;
            end
        end
    end

    // Expected colour bits straight from the pixel word layout.
    function automatic logic [5:0] exp_bits(input int line, input int plane, input int c);
        logic [11:0] w;
        logic [1:0]  xr1, xg1, xb1, xr2, xg2, xb2;
        w = fb[line*COLS + c];
        {xr1, xg1, xb1, xr2, xg2, xb2} = w;
        return {xr1[plane], xg1[plane], xb1[plane], xr2[plane], xg2[plane], xb2[plane]};
    endfunction

    task automatic check_group(input int idx, input int line, input int plane, input int fs_exp);
        grp_t g;
        if (idx >= obs.size()) begin
            checks++; errors++;
            $display("FAIL group%0d: only %0d groups seen, required %0d", idx, obs.size(), idx + 1);
            return;
        end
        g = obs[idx];
        chk($sformatf("row[%0d]", idx), g.row, line);
        chk($sformatf("nclk[%0d]", idx), g.nclk, COLS);
        for (int c = 0; c < COLS; c++)
            chk($sformatf("bits[%0d][%0d]", idx, c), int'(g.s[6*c +: 6]),
                int'(exp_bits(line, plane, c)));
        chk($sformatf("oe[%0d]", idx), g.oe_clks, (BASE_OE << plane) * CLK_DIV);
        chk($sformatf("fs[%0d]", idx), g.fs, fs_exp);
    endtask

    task automatic wait_groups(input int n);
        int b = 0;
        while (obs.size() < n && b < 3000) begin
            @(negedge clk); b++;
        end
        if (obs.size() < n) begin
            checks++; errors++;
            $display("FAIL timeout: %0d groups, required %0d", obs.size(), n);
        end
    endtask

    typedef struct { int line; int plane; int fs; } vec_t;
    vec_t tbl[9];

    initial begin
        int first, b;
        tbl[0] = '{0, 0, 0}; tbl[1] = '{0, 1, 0};
        tbl[2] = '{1, 0, 0}; tbl[3] = '{1, 1, 0};
        tbl[4] = '{2, 0, 0}; tbl[5] = '{2, 1, 0};
        tbl[6] = '{3, 0, 0}; tbl[7] = '{3, 1, 1};
        tbl[8] = '{0, 0, 0};
        for (int i = 0; i < 16; i++) fb[i] = 12'($urandom);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_oe", int'(hoe), 1);
        chk("rst_clk_lat", int'({hclk, hlat}), 0);
        chk("rst_rgb", int'({r1, g1, b1, r2, g2, b2}), 0);
        chk("rst_row", int'({he, hd, hc, hb, ha}), 0);
        chk("rst_fs", int'(fs), 0);
        chk("rst_addr", int'(rd_addr), 0);
        rst2 = 1'b0;

        enable = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        first = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (first == 0 && rd_addr != 4'd0) first = k;
        end
        chk("first_tick_clk", first, CLK_DIV);

        wait_groups(9);
        for (int i = 0; i < 9; i++) check_group(i, tbl[i].line, tbl[i].plane, tbl[i].fs);
        chk("fs_count", fs_count, 1);

        // drop enable during SHIFT of line 1 plane 0
        wait_groups(10);
        repeat (4) @(negedge clk);
        enable = 1'b0;
        wait_groups(11);
        check_group(10, 1, 0, 0);
        repeat (60) @(negedge clk);
        chk("idle_groups", obs.size(), 11);
        chk("idle_no_clk", ns, 0);
        chk("idle_oe", int'(hoe), 1);
        chk("idle_addr", int'(rd_addr), 4);
        enable = 1'b1;
        wait_groups(12);
        check_group(11, 1, 1, 0);

        // reset pulse during SHOW of line 2 plane 1
        wait_groups(13);
        b = 0;
        while (hoe && b < 200) begin
            @(negedge clk); b++;
        end
        chk("show_reached", int'(hoe), 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_oe", int'(hoe), 1);
        chk("rst_async_row", int'({he, hd, hc, hb, ha}), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        wait_groups(14);
        check_group(13, 0, 0, 0);

        b = 0;
        while (nruns2 < 4 && b < 25000) begin
            @(negedge clk); b++;
        end
        chk("dflt_clk_period", period2, 54);
        chk("dflt_plane3_oe", run3_len, 432);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
